// File: rtl/sdram_port_arbiter_pkg.sv
// rtl/sdram_port_arbiter_pkg.sv - shared widths, port ids and read-tag encoding for the SDRAM port arbiter
package sdram_port_arbiter_pkg;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 256;

    // Tag stored per outstanding read: which requester gets the returning beat.
    typedef enum logic {
        SRC_VGA = 1'b0,
        SRC_HDR = 1'b1
    } rd_src_e;

    typedef enum logic [1:0] {
        PORT_NONE = 2'd0,
        PORT_VGA  = 2'd1,
        PORT_CAM  = 2'd2,
        PORT_HDR  = 2'd3
    } port_e;

endpackage

// File: rtl/sdram_port_arbiter_rd_tag_fifo.sv
// rtl/sdram_port_arbiter_rd_tag_fifo.sv - 1-bit read-source tag FIFO with same-cycle push and pop
module sdram_port_arbiter_rd_tag_fifo #(
    parameter int DEPTH = 8
) (
    input  logic clk_133M,
    input  logic rst_n_133M,
    input  logic push,
    input  logic push_src,
    input  logic pop,
    output logic pop_src,
    output logic full,
    output logic empty
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pop_src = mem[rd_ptr[PW-1:0]];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk_133M or negedge rst_n_133M) begin
        if (!rst_n_133M) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_133M) begin
        if (do_push) begin
            mem[wr_ptr[PW-1:0]] <= push_src;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - shares the SDRAM command port between VGA reads, camera writes and HDR reads
module sdram_port_arbiter
    import sdram_port_arbiter_pkg::*;
#(
    parameter int TAG_DEPTH  = 8,
    parameter int STARVE_LIM = 64
) (
    input  logic              clk_133M,
    input  logic              rst_n_133M,
    input  logic              vga_rd_req,
    input  logic [ADDR_W-1:0] vga_rd_address,
    input  logic              cam_wr_req,
    input  logic [ADDR_W-1:0] cam_wr_address,
    input  logic [DATA_W-1:0] cam_wr_data,
    input  logic              hdr_rd_req,
    input  logic [ADDR_W-1:0] hdr_rd_address,
    input  logic              ram_busy,
    input  logic              ram_rd_valid,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              vga_busy,
    output logic              cam_busy,
    output logic              hdr_busy,
    output logic              vga_rd_valid,
    output logic              hdr_rd_valid,
    output logic              err_overrun,
    output logic              err_orphan
);

    localparam int SW = $clog2(STARVE_LIM + 1);

    logic              vga_pend;
    logic              cam_pend;
    logic              hdr_pend;
    logic [ADDR_W-1:0] vga_addr_q;
    logic [ADDR_W-1:0] cam_addr_q;
    logic [DATA_W-1:0] cam_data_q;
    logic [ADDR_W-1:0] hdr_addr_q;
    logic [SW-1:0]     starve_cnt;
    logic              starve_force;
    port_e             grant;
    logic              tag_push;
    logic              tag_push_src;
    logic              tag_head;
    logic              tag_full;
    logic              tag_empty;

    assign vga_busy     = vga_pend;
    assign cam_busy     = cam_pend;
    assign hdr_busy     = hdr_pend;
    assign starve_force = (starve_cnt >= SW'(STARVE_LIM));

    // Blocking on ram_req leaves one idle cycle so ram_busy can reflect the previous command.
    always_comb begin
        grant = PORT_NONE;
        if (!ram_busy && !ram_req) begin
            if (starve_force && hdr_pend && !tag_full) begin
                grant = PORT_HDR;
            end else if (vga_pend && !tag_full) begin
                grant = PORT_VGA;
            end else if (cam_pend) begin
                grant = PORT_CAM;
            end else if (hdr_pend && !tag_full) begin
                grant = PORT_HDR;
            end
        end
    end

    always_ff @(posedge clk_133M or negedge rst_n_133M) begin
        if (!rst_n_133M) begin
            vga_pend    <= 1'b0;
            cam_pend    <= 1'b0;
            hdr_pend    <= 1'b0;
            vga_addr_q  <= '0;
            cam_addr_q  <= '0;
            cam_data_q  <= '0;
            hdr_addr_q  <= '0;
            err_overrun <= 1'b0;
        end else begin
            // Capture needs pending low and grant needs it high, so the branches never collide.
            if (vga_rd_req && !vga_pend) begin
                vga_pend   <= 1'b1;
                vga_addr_q <= vga_rd_address;
            end else if (grant == PORT_VGA) begin
                vga_pend <= 1'b0;
            end
            if (cam_wr_req && !cam_pend) begin
                cam_pend   <= 1'b1;
                cam_addr_q <= cam_wr_address;
                cam_data_q <= cam_wr_data;
            end else if (grant == PORT_CAM) begin
                cam_pend <= 1'b0;
            end
            if (hdr_rd_req && !hdr_pend) begin
                hdr_pend   <= 1'b1;
                hdr_addr_q <= hdr_rd_address;
            end else if (grant == PORT_HDR) begin
                hdr_pend <= 1'b0;
            end
            if ((vga_rd_req && vga_pend) || (cam_wr_req && cam_pend) || (hdr_rd_req && hdr_pend)) begin
                err_overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_133M or negedge rst_n_133M) begin
        if (!rst_n_133M) begin
            starve_cnt <= '0;
        end else if (hdr_pend && (grant != PORT_HDR)) begin
            if (starve_cnt != SW'(STARVE_LIM)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    always_ff @(posedge clk_133M or negedge rst_n_133M) begin
        if (!rst_n_133M) begin
            ram_req     <= 1'b0;
            ram_we      <= 1'b0;
            ram_address <= '0;
            ram_wr_data <= '0;
        end else begin
            ram_req <= (grant != PORT_NONE);
            ram_we  <= (grant == PORT_CAM);
            case (grant)
                PORT_VGA: ram_address <= vga_addr_q;
                PORT_HDR: ram_address <= hdr_addr_q;
                PORT_CAM: begin
                    ram_address <= cam_addr_q;
                    ram_wr_data <= cam_data_q;
                end
                default: ;
            endcase
        end
    end

    assign tag_push     = (grant == PORT_VGA) || (grant == PORT_HDR);
    assign tag_push_src = (grant == PORT_HDR) ? SRC_HDR : SRC_VGA;

    sdram_port_arbiter_rd_tag_fifo #(
        .DEPTH(TAG_DEPTH)
    ) u_rd_tag_fifo (
        .clk_133M  (clk_133M),
        .rst_n_133M(rst_n_133M),
        .push      (tag_push),
        .push_src  (tag_push_src),
        .pop       (ram_rd_valid),
        .pop_src   (tag_head),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    // Return beats are steered by the tag at the head; a beat with no tag goes nowhere.
    assign vga_rd_valid = ram_rd_valid && !tag_empty && (tag_head == SRC_VGA);
    assign hdr_rd_valid = ram_rd_valid && !tag_empty && (tag_head == SRC_HDR);

    always_ff @(posedge clk_133M or negedge rst_n_133M) begin
        if (!rst_n_133M) begin
            err_orphan <= 1'b0;
        end else if (ram_rd_valid && tag_empty) begin
            err_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - directed scoreboard bench for sdram_port_arbiter
module tb_sdram_port_arbiter;

    typedef struct {
        logic        we;
        logic [24:0] addr;
        logic [255:0] data;
    } cmd_t;

    logic         clk_133M = 1'b0;
    logic         rst_n_133M;
    logic         vga_rd_req;
    logic [24:0]  vga_rd_address;
    logic         cam_wr_req;
    logic [24:0]  cam_wr_address;
    logic [255:0] cam_wr_data;
    logic         hdr_rd_req;
    logic [24:0]  hdr_rd_address;
    logic         ram_busy;
    logic         ram_rd_valid;
    logic         ram_req;
    logic         ram_we;
    logic [24:0]  ram_address;
    logic [255:0] ram_wr_data;
    logic         vga_busy;
    logic         cam_busy;
    logic         hdr_busy;
    logic         vga_rd_valid;
    logic         hdr_rd_valid;
    logic         err_overrun;
    logic         err_orphan;

    cmd_t exp_q[$];
    cmd_t obs_q[$];
    logic exp_src_q[$];
    cmd_t mon_c;
    int   n_tests = 0;
    int   n_fail = 0;
    int   b2b = 0;
    logic prev_req = 1'b0;
    int   outstanding;
    int   hdr_seen_at;

    always #4 clk_133M = ~clk_133M;

    sdram_port_arbiter #(
        .TAG_DEPTH (8),
        .STARVE_LIM(64)
    ) dut (
        .clk_133M      (clk_133M),
        .rst_n_133M    (rst_n_133M),
        .vga_rd_req    (vga_rd_req),
        .vga_rd_address(vga_rd_address),
        .cam_wr_req    (cam_wr_req),
        .cam_wr_address(cam_wr_address),
        .cam_wr_data   (cam_wr_data),
        .hdr_rd_req    (hdr_rd_req),
        .hdr_rd_address(hdr_rd_address),
        .ram_busy      (ram_busy),
        .ram_rd_valid  (ram_rd_valid),
        .ram_req       (ram_req),
        .ram_we        (ram_we),
        .ram_address   (ram_address),
        .ram_wr_data   (ram_wr_data),
        .vga_busy      (vga_busy),
        .cam_busy      (cam_busy),
        .hdr_busy      (hdr_busy),
        .vga_rd_valid  (vga_rd_valid),
        .hdr_rd_valid  (hdr_rd_valid),
        .err_overrun   (err_overrun),
        .err_orphan    (err_orphan)
    );

    always @(negedge clk_133M) begin
        if (ram_req) begin
            mon_c.we   = ram_we;
            mon_c.addr = ram_address;
            mon_c.data = ram_wr_data;
            obs_q.push_back(mon_c);
            if (prev_req) b2b++;
        end
        prev_req = ram_req;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_133M);
        #1;
    endtask

    task automatic push_exp(input logic we, input logic [24:0] addr, input logic [255:0] data);
        cmd_t c;
        c.we = we;
        c.addr = addr;
        c.data = data;
        exp_q.push_back(c);
    endtask

    task automatic expect_cmd(input string tag);
        cmd_t o;
        cmd_t e;
        int n = 0;
        while (obs_q.size() == 0 && n < 60) begin
            tick();
            n++;
        end
        if (obs_q.size() == 0) begin
            chk({tag, " timeout"}, 0, 1);
            return;
        end
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        chk({tag, " we"}, o.we, e.we);
        chk({tag, " addr"}, o.addr, e.addr);
        if (e.we) chk({tag, " data"}, o.data, e.data);
    endtask

    task automatic ret(input string tag);
        logic e;
        ram_rd_valid = 1'b1;
        #1;
        e = exp_src_q.pop_front();
        chk({tag, " vga_rd_valid"}, vga_rd_valid, !e);
        chk({tag, " hdr_rd_valid"}, hdr_rd_valid, e);
        tick();
        ram_rd_valid = 1'b0;
    endtask

    task automatic issue_rd(input string tag, input logic is_hdr, input logic [24:0] addr);
        int n = 0;
        while ((is_hdr ? hdr_busy : vga_busy) && n < 40) begin
            tick();
            n++;
        end
        if (is_hdr ? hdr_busy : vga_busy) chk({tag, " busy timeout"}, 1, 0);
        if (is_hdr) begin
            hdr_rd_address = addr;
            hdr_rd_req = 1'b1;
        end else begin
            vga_rd_address = addr;
            vga_rd_req = 1'b1;
        end
        push_exp(1'b0, addr, '0);
        exp_src_q.push_back(is_hdr);
        tick();
        vga_rd_req = 1'b0;
        hdr_rd_req = 1'b0;
    endtask

    task automatic traffic_step(input int j, input logic on);
        if (ram_req && !ram_we) begin
            outstanding++;
            if (ram_address == 25'h1234 && hdr_seen_at < 0) hdr_seen_at = j;
        end
        vga_rd_req   = on && !vga_busy;
        cam_wr_req   = on && !cam_busy;
        hdr_rd_req   = on && (j == 0);
        ram_rd_valid = (outstanding > 0);
        if (ram_rd_valid) outstanding--;
        tick();
    endtask

    initial begin
        rst_n_133M = 1'b0;
        vga_rd_req = 1'b0;
        vga_rd_address = '0;
        cam_wr_req = 1'b0;
        cam_wr_address = '0;
        cam_wr_data = '0;
        hdr_rd_req = 1'b0;
        hdr_rd_address = '0;
        ram_busy = 1'b0;
        ram_rd_valid = 1'b0;
        repeat (3) tick();
        chk("rst ram_req", ram_req, 0);
        chk("rst ram_we", ram_we, 0);
        chk("rst ram_address", ram_address, 0);
        chk("rst busy", {vga_busy, cam_busy, hdr_busy}, 0);
        chk("rst valids", {vga_rd_valid, hdr_rd_valid}, 0);
        chk("rst errs", {err_overrun, err_orphan}, 0);
        rst_n_133M = 1'b1;
        tick();

        // single VGA read, latency and routing
        vga_rd_address = 25'h25800;
        vga_rd_req = 1'b1;
        push_exp(1'b0, 25'h25800, '0);
        exp_src_q.push_back(1'b0);
        tick();
        vga_rd_req = 1'b0;
        chk("t1 ram_req c1", ram_req, 0);
        chk("t1 vga_busy c1", vga_busy, 1);
        tick();
        chk("t1 ram_req c2", ram_req, 1);
        chk("t1 ram_we", ram_we, 0);
        chk("t1 ram_address", ram_address, 25'h25800);
        chk("t1 vga_busy c2", vga_busy, 0);
        expect_cmd("t1 cmd");
        repeat (3) tick();
        ret("t1 route");

        // three simultaneous requests
        vga_rd_address = 25'h00111;
        cam_wr_address = 25'h00222;
        cam_wr_data = {8{32'hCAFE0001}};
        hdr_rd_address = 25'h00333;
        vga_rd_req = 1'b1;
        cam_wr_req = 1'b1;
        hdr_rd_req = 1'b1;
        push_exp(1'b0, 25'h00111, '0);
        push_exp(1'b1, 25'h00222, {8{32'hCAFE0001}});
        push_exp(1'b0, 25'h00333, '0);
        exp_src_q.push_back(1'b0);
        exp_src_q.push_back(1'b1);
        tick();
        vga_rd_req = 1'b0;
        cam_wr_req = 1'b0;
        hdr_rd_req = 1'b0;
        expect_cmd("t2 vga");
        chk("t2 busy after vga", {vga_busy, cam_busy, hdr_busy}, 3'b011);
        expect_cmd("t2 cam");
        chk("t2 busy after cam", {vga_busy, cam_busy, hdr_busy}, 3'b001);
        expect_cmd("t2 hdr");
        chk("t2 busy after hdr", {vga_busy, cam_busy, hdr_busy}, 3'b000);
        repeat (2) tick();
        ret("t2 route v");
        ret("t2 route h");

        // HDR starvation under continuous VGA+CAM traffic
        vga_rd_address = 25'h00300;
        cam_wr_address = 25'h00400;
        hdr_rd_address = 25'h1234;
        outstanding = 0;
        hdr_seen_at = -1;
        for (int j = -8; j < 100; j++) traffic_step(j, 1'b1);
        for (int j = 100; j < 140; j++) traffic_step(j, 1'b0);
        ram_rd_valid = 1'b0;
        chk("t3 hdr grant window", (hdr_seen_at == 66 || hdr_seen_at == 67), 1);
        chk("t3 outstanding drained", outstanding, 0);
        chk("t3 busy idle", {vga_busy, cam_busy, hdr_busy}, 0);
        chk("t3 no orphan", err_orphan, 0);
        obs_q.delete();

        // tag FIFO full stalls the ninth read
        for (int i = 0; i < 9; i++) issue_rd("t4 issue", 1'b0, 25'h00100 + 25'(i));
        for (int i = 0; i < 8; i++) expect_cmd("t4 cmd");
        repeat (10) tick();
        chk("t4 ninth held busy", vga_busy, 1);
        chk("t4 ninth not issued", obs_q.size(), 0);
        ret("t4 route first");
        expect_cmd("t4 ninth cmd");
        for (int i = 0; i < 8; i++) ret("t4 route");

        // interleaved sources, then same-cycle push and pop
        issue_rd("t5 v0", 1'b0, 25'h00501);
        expect_cmd("t5 v0 cmd");
        issue_rd("t5 h0", 1'b1, 25'h00502);
        expect_cmd("t5 h0 cmd");
        issue_rd("t5 h1", 1'b1, 25'h00503);
        expect_cmd("t5 h1 cmd");
        issue_rd("t5 v1", 1'b0, 25'h00504);
        expect_cmd("t5 v1 cmd");
        repeat (3) tick();
        vga_rd_address = 25'h00505;
        vga_rd_req = 1'b1;
        push_exp(1'b0, 25'h00505, '0);
        tick();
        vga_rd_req = 1'b0;
        ret("t5 pushpop head");
        exp_src_q.push_back(1'b0);
        expect_cmd("t5 pushpop cmd");
        ret("t5 route h0");
        ret("t5 route h1");
        ret("t5 route v1");
        ret("t5 route v2");
        ram_rd_valid = 1'b1;
        #1;
        chk("t6 orphan valids", {vga_rd_valid, hdr_rd_valid}, 0);
        tick();
        ram_rd_valid = 1'b0;
        chk("t6 err_orphan", err_orphan, 1);

        // overrun keeps the original request
        ram_busy = 1'b1;
        vga_rd_address = 25'h00AAA;
        vga_rd_req = 1'b1;
        tick();
        vga_rd_req = 1'b0;
        tick();
        chk("t6 no overrun yet", err_overrun, 0);
        vga_rd_address = 25'h00BBB;
        vga_rd_req = 1'b1;
        tick();
        vga_rd_req = 1'b0;
        chk("t6 err_overrun", err_overrun, 1);
        repeat (4) tick();
        chk("t6 held by ram_busy", obs_q.size(), 0);
        ram_busy = 1'b0;
        push_exp(1'b0, 25'h00AAA, '0);
        exp_src_q.push_back(1'b0);
        expect_cmd("t6 original addr");
        repeat (2) tick();
        ret("t6 route");

        // reset mid-operation discards pending work
        ram_busy = 1'b1;
        cam_wr_address = 25'h00CCC;
        cam_wr_req = 1'b1;
        tick();
        cam_wr_req = 1'b0;
        chk("rst2 cam_busy before", cam_busy, 1);
        rst_n_133M = 1'b0;
        tick();
        chk("rst2 cam_busy after", cam_busy, 0);
        chk("rst2 errs cleared", {err_overrun, err_orphan}, 0);
        rst_n_133M = 1'b1;
        ram_busy = 1'b0;
        repeat (5) tick();
        chk("rst2 nothing issued", obs_q.size(), 0);
        chk("no back-to-back ram_req", b2b, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
